// File: rtl/led_blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
// Channel modes are kept in a two-bit enum so the encoding matches the
// cfg_mode field written by software.

package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  // Board clock and tick rates used to derive the default prescaler divide.
  localparam int CLK_HZ  = 50_000_000;
  localparam int TICK_HZ = 1_000;

  // CLK_50 cycles per 1 ms tick.
  localparam int TICK_DIV_DEFAULT = CLK_HZ / TICK_HZ;

  // Width of the channel select field; a single channel still needs one bit.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode, effective half-period, tick counter and
// lit bit. A configuration load always takes priority over a tick arriving in
// the same cycle, so a freshly written channel starts counting from zero.

module led_channel
  import led_blink_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                load,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] half,
  output logic                lit,
  output logic                done
);

  mode_e               mode_q;
  mode_e               mode_d;
  logic [PERIOD_W-1:0] half_q;
  logic [PERIOD_W-1:0] half_d;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic                lit_q;
  logic                lit_d;
  logic                done_q;
  logic                done_d;
  logic                last_tick;
  mode_e               load_mode;
  logic [PERIOD_W-1:0] load_half;

  // The half-period is never stored as zero, so half_q - 1 cannot wrap while
  // a timed mode is active.
  assign last_tick = (cnt_q == (half_q - PERIOD_W'(1)));
  assign load_mode = mode_e'(mode);
  assign load_half = (half == '0) ? PERIOD_W'(1) : half;

  // State register: mode, half-period, tick counter, lit bit and done strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_OFF;
      half_q <= PERIOD_W'(1);
      cnt_q  <= '0;
      lit_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      lit_q  <= lit_d;
      done_q <= done_d;
    end
  end

  // Next-state logic: a load overrides any tick; otherwise BLINK and PULSE
  // advance their counters on each tick and act when the half-period expires.
  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    lit_d  = lit_q;
    done_d = 1'b0;

    if (load) begin
      mode_d = load_mode;
      half_d = load_half;
      cnt_d  = '0;
      lit_d  = (load_mode != MODE_OFF);
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (last_tick) begin
            cnt_d = '0;
            lit_d = ~lit_q;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        MODE_PULSE: begin
          if (last_tick) begin
            lit_d  = 1'b0;
            mode_d = MODE_OFF;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  assign lit  = lit_q;
  assign done = done_q;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver for the Kiwi board. A free-running prescaler
// produces a shared tick; each channel is configured independently and drives
// one bit of the active-low LED bank. The prescaler ignores configuration
// writes, so all channels stay aligned to the same tick grid.

module led_blinker_multi
  import led_blink_pkg::*;
#(
  parameter  int N_CH     = 8,
  parameter  int TICK_DIV = TICK_DIV_DEFAULT,
  parameter  int PERIOD_W = 16,
  localparam int CH_W     = ch_width(N_CH)
) (
  input  logic                CLK_50,
  input  logic                RESET,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half,
  output logic [N_CH-1:0]     LED,
  output logic [N_CH-1:0]     pulse_done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  lit;

  // The tick is high for the single cycle in which the prescaler sits at its
  // terminal count; with TICK_DIV of 1 it is high every cycle.
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // Prescaler: counts 0..TICK_DIV-1 and wraps, cleared only by reset.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Address decode: one load strobe per channel; a select beyond the last
  // channel matches nothing and the write is dropped.
  always_comb begin
    load = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_valid && (cfg_chan == CH_W'(i))) begin
        load[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    led_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_chan (
      .clk   (CLK_50),
      .reset (RESET),
      .tick  (tick),
      .load  (load[g]),
      .mode  (cfg_mode),
      .half  (cfg_half),
      .lit   (lit[g]),
      .done  (pulse_done[g])
    );
  end

  // The LEDs sink current, so a lit channel pulls its pin low.
  assign LED = ~lit;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed testbench for led_blinker_multi. The main instance uses N_CH=4,
// TICK_DIV=4, PERIOD_W=8. A second five-channel instance exercises writes to
// channel numbers beyond the last channel, which a two-bit select cannot hold.
// Timeline: N_k is the falling edge after the k-th rising edge following reset
// release; with TICK_DIV=4 the shared tick is consumed on rising edges 4, 8, 12...

module tb_led_blinker_multi;

  logic       CLK_50;
  logic       RESET;

  logic       cfg_valid;
  logic [1:0] cfg_chan;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_half;
  logic [3:0] LED;
  logic [3:0] pulse_done;

  logic       cfg2_valid;
  logic [2:0] cfg2_chan;
  logic [1:0] cfg2_mode;
  logic [7:0] cfg2_half;
  logic [4:0] led2;
  logic [4:0] pulse_done2;

  int n_compared;
  int n_mismatch;
  int edge_k;

  led_blinker_multi #(
    .N_CH     (4),
    .TICK_DIV (4),
    .PERIOD_W (8)
  ) dut (
    .CLK_50     (CLK_50),
    .RESET      (RESET),
    .cfg_valid  (cfg_valid),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_half   (cfg_half),
    .LED        (LED),
    .pulse_done (pulse_done)
  );

  led_blinker_multi #(
    .N_CH     (5),
    .TICK_DIV (4),
    .PERIOD_W (8)
  ) dut_five (
    .CLK_50     (CLK_50),
    .RESET      (RESET),
    .cfg_valid  (cfg2_valid),
    .cfg_chan   (cfg2_chan),
    .cfg_mode   (cfg2_mode),
    .cfg_half   (cfg2_half),
    .LED        (led2),
    .pulse_done (pulse_done2)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  // Drive one configuration write (or idle) on the selected instance.
  task automatic applyStimulus(input int target, input logic valid, input logic [2:0] chan,
                               input logic [1:0] mode, input logic [7:0] half);
    if (target == 0) begin
      cfg_valid = valid;
      cfg_chan  = chan[1:0];
      cfg_mode  = mode;
      cfg_half  = half;
    end else begin
      cfg2_valid = valid;
      cfg2_chan  = chan;
      cfg2_mode  = mode;
      cfg2_half  = half;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatch++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance to falling edge N_k.
  task automatic goTo(input int k);
    while (edge_k < k) begin
      @(negedge CLK_50);
      edge_k++;
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatch = 0;
    edge_k     = 0;

    RESET = 1'b1;
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    applyStimulus(1, 1'b0, 3'd0, 2'd0, 8'd0);
    repeat (3) @(negedge CLK_50);
    $display("[TB] reset held for 3 cycles");
    checkOutput("reset_led",         {4'b0, LED},         8'b0000_1111);
    checkOutput("reset_pulse_done",  {4'b0, pulse_done},  8'b0000_0000);
    checkOutput("reset_led_five",    {3'b0, led2},        8'b0001_1111);
    checkOutput("reset_pdone_five",  {3'b0, pulse_done2}, 8'b0000_0000);
    RESET  = 1'b0;
    edge_k = 0;

    // Channel 1 BLINK, half=2: lit from edge 2, toggles on edges 8, 16, 24...
    goTo(1);
    applyStimulus(0, 1'b1, 3'd1, 2'd2, 8'd2);
    goTo(2);
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("blink_start",       {4'b0, LED},        8'b0000_1101);

    // Five-channel instance: valid write to ch1, then writes to 5, 6, 7.
    goTo(3);
    applyStimulus(1, 1'b1, 3'd1, 2'd1, 8'd0);
    goTo(4);
    checkOutput("five_ch1_on",       {3'b0, led2},       8'b0001_1101);
    applyStimulus(1, 1'b1, 3'd5, 2'd0, 8'd0);
    goTo(5);
    applyStimulus(1, 1'b1, 3'd6, 2'd0, 8'd0);
    goTo(6);
    applyStimulus(1, 1'b1, 3'd7, 2'd3, 8'd1);
    goTo(7);
    applyStimulus(1, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("bad_chan_ignored",  {3'b0, led2},       8'b0001_1101);
    checkOutput("blink_first_phase", {4'b0, LED},        8'b0000_1101);

    goTo(8);
    checkOutput("blink_toggle_off",  {4'b0, LED},        8'b0000_1111);
    applyStimulus(1, 1'b1, 3'd4, 2'd1, 8'd0);
    goTo(9);
    applyStimulus(1, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("five_ch4_on",       {3'b0, led2},       8'b0000_1101);
    checkOutput("five_no_pdone",     {3'b0, pulse_done2}, 8'b0000_0000);

    goTo(15);
    checkOutput("blink_dark_hold",   {4'b0, LED},        8'b0000_1111);
    goTo(16);
    checkOutput("blink_toggle_on",   {4'b0, LED},        8'b0000_1101);

    // Channel 2 PULSE, half=3: lit on edge 18, expires on tick edge 28.
    goTo(17);
    applyStimulus(0, 1'b1, 3'd2, 2'd3, 8'd3);
    goTo(18);
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("pulse_start",       {4'b0, LED},        8'b0000_1001);
    goTo(24);
    checkOutput("pulse_mid",         {4'b0, LED},        8'b0000_1011);
    goTo(27);
    checkOutput("pulse_last_lit",    {4'b0, LED},        8'b0000_1011);
    checkOutput("pulse_not_done",    {4'b0, pulse_done}, 8'b0000_0000);
    goTo(28);
    checkOutput("pulse_end_led",     {4'b0, LED},        8'b0000_1111);
    checkOutput("pulse_done_strobe", {4'b0, pulse_done}, 8'b0000_0100);
    goTo(29);
    checkOutput("pulse_done_clear",  {4'b0, pulse_done}, 8'b0000_0000);
    checkOutput("pulse_stays_dark",  {4'b0, LED},        8'b0000_1111);

    // Channel 0 BLINK with half=0 behaves as half=1: toggles on every tick.
    applyStimulus(0, 1'b1, 3'd0, 2'd2, 8'd0);
    goTo(30);
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("zero_half_start",   {4'b0, LED},        8'b0000_1110);
    goTo(32);
    checkOutput("zero_half_tick1",   {4'b0, LED},        8'b0000_1101);
    goTo(35);
    checkOutput("zero_half_hold",    {4'b0, LED},        8'b0000_1101);
    goTo(36);
    checkOutput("zero_half_tick2",   {4'b0, LED},        8'b0000_1100);

    // Channel 3 written on the same edge as a tick (edge 40).
    goTo(39);
    applyStimulus(0, 1'b1, 3'd3, 2'd2, 8'd2);
    goTo(40);
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("collide_edge",      {4'b0, LED},        8'b0000_0111);
    goTo(44);
    checkOutput("collide_tick_lost", {4'b0, LED},        8'b0000_0110);
    goTo(47);
    checkOutput("collide_hold",      {4'b0, LED},        8'b0000_0110);
    goTo(48);
    checkOutput("collide_toggle",    {4'b0, LED},        8'b0000_1101);

    // Channel 2 PULSE half=5 (would expire on edge 68), reset at edge 62.
    goTo(49);
    applyStimulus(0, 1'b1, 3'd2, 2'd3, 8'd5);
    goTo(50);
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    checkOutput("long_pulse_start",  {4'b0, LED},        8'b0000_1001);
    goTo(52);
    checkOutput("multi_run_52",      {4'b0, LED},        8'b0000_1000);
    goTo(56);
    checkOutput("multi_run_56",      {4'b0, LED},        8'b0000_0011);
    goTo(61);
    checkOutput("before_reset",      {4'b0, LED},        8'b0000_0010);
    RESET = 1'b1;
    applyStimulus(0, 1'b1, 3'd1, 2'd1, 8'd3);
    goTo(62);
    checkOutput("mid_reset_led",     {4'b0, LED},        8'b0000_1111);
    checkOutput("mid_reset_pdone",   {4'b0, pulse_done}, 8'b0000_0000);
    checkOutput("mid_reset_five",    {3'b0, led2},       8'b0001_1111);
    goTo(64);
    applyStimulus(0, 1'b0, 3'd0, 2'd0, 8'd0);
    RESET = 1'b0;
    checkOutput("reset_hold_led",    {4'b0, LED},        8'b0000_1111);

    for (int j = 0; j < 12; j++) begin
      goTo(65 + j);
      checkOutput("post_reset_led",   {4'b0, LED},        8'b0000_1111);
      checkOutput("post_reset_pdone", {4'b0, pulse_done}, 8'b0000_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
